z80_sequencer: RTL

Z80_SEQUENCER -- requirements
Module: z80_sequencer

---
 rtl/z80_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/z80_sequencer.sv
// Z80-subset instruction sequencer: fetch, decode and control strobes for
// NOP, LD r,n, LD r,r', 8-bit ALU on registers, and HALT.
module z80_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_bus,
  input  logic        mem_ready,
  output logic        mem_rd,
  output logic        pc_inc,
  output logic        m1,
  output logic        read,
  output logic [3:0]  RE,
  output logic [15:0] WE,
  output logic [7:0]  alu_ld_r,
  output logic [3:0]  alu_re_r,
  output logic [2:0]  alu_op,
  output logic [7:0]  ir,
  output logic        halted,
  output logic        illegal
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_OPERAND = 3'd2;
  localparam logic [2:0] S_XFER    = 3'd3;
  localparam logic [2:0] S_EXEC    = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_HALTED  = 3'd6;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [2:0] w_dec_next;
  logic [7:0] r_ir;
  logic       w_bad;

  logic [2:0] w_dst;
  logic [2:0] w_src;
  logic       w_dst_m;
  logic       w_src_m;
  logic       w_is_nop;
  logic       w_is_ldn;
  logic       w_is_halt;
  logic       w_is_xfer;
  logic       w_is_alu;

  logic        w_mem_rd;
  logic        w_m1;
  logic        w_pc_inc;
  logic        w_read;
  logic [3:0]  w_re;
  logic [15:0] w_we;
  logic [7:0]  w_ld;
  logic [3:0]  w_are;
  logic [2:0]  w_op;
  logic        w_hlt;
  logic        w_ill;

  // rrr -> register-file select: A is 0, B..L are 2..7
  function automatic logic [3:0] f_code(input logic [2:0] rrr);
    f_code = (rrr == 3'b111) ? 4'd0 : {1'b0, rrr} + 4'd2;
  endfunction

  function automatic logic [15:0] f_we(input logic [2:0] rrr);
    f_we = 16'h0001 << (f_code(rrr) + 4'd2);
  endfunction

  assign w_dst   = r_ir[5:3];
  assign w_src   = r_ir[2:0];
  assign w_dst_m = (w_dst == 3'b110);
  assign w_src_m = (w_src == 3'b110);

  assign w_is_nop  = (r_ir == 8'h00);
  assign w_is_halt = (r_ir == 8'h76);
  assign w_is_ldn  = (r_ir[7:6] == 2'b00) && w_src_m && !w_dst_m;
  assign w_is_xfer = (r_ir[7:6] == 2'b01) && !w_src_m && !w_dst_m;
  assign w_is_alu  = (r_ir[7:6] == 2'b10) && !w_src_m;

  always_comb begin
    w_dec_next = S_FETCH;
    w_bad      = 1'b0;
    unique case (1'b1)
      w_is_nop:  w_dec_next = S_FETCH;
      w_is_ldn:  w_dec_next = S_OPERAND;
      w_is_halt: w_dec_next = S_HALTED;
      w_is_xfer: w_dec_next = S_XFER;
      w_is_alu:  w_dec_next = S_EXEC;
      default:   w_bad      = 1'b1;
    endcase
  end

  always_comb begin
    w_next = S_FETCH;
    unique case (r_state)
      S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  w_next = w_dec_next;
      S_OPERAND: w_next = mem_ready ? S_FETCH : S_OPERAND;
      S_XFER:    w_next = S_FETCH;
      S_EXEC:    w_next = S_WB;
      S_WB:      w_next = S_FETCH;
      S_HALTED:  w_next = S_HALTED;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_mem_rd = 1'b0;
    w_m1     = 1'b0;
    w_pc_inc = 1'b0;
    w_read   = 1'b0;
    w_re     = 4'd0;
    w_we     = 16'h0000;
    w_ld     = 8'h00;
    w_are    = 4'd0;
    w_op     = 3'd0;
    w_hlt    = 1'b0;
    w_ill    = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_mem_rd = 1'b1;
        w_m1     = 1'b1;
        w_pc_inc = mem_ready;
      end
      S_DECODE: w_ill = w_bad;
      S_OPERAND: begin
        w_mem_rd = 1'b1;
        if (mem_ready) begin
          w_pc_inc = 1'b1;
          w_we     = f_we(w_dst);
        end
      end
      S_XFER: begin
        w_read = 1'b1;
        w_re   = f_code(w_src);
        w_we   = f_we(w_dst);
      end
      S_EXEC: begin
        w_are = f_code(w_src);
        w_op  = w_dst;
      end
      // CP only updates flags
      S_WB: begin
        w_are = f_code(w_src);
        w_op  = w_dst;
        w_ld  = (w_dst == 3'b111) ? 8'h80 : 8'h81;
      end
      S_HALTED: w_hlt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ir    <= 8'h00;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && mem_ready)
        r_ir <= data_bus;
    end
  end

  // while reset is held only the fetch request is visible
  assign mem_rd   = w_mem_rd;
  assign m1       = w_m1;
  assign pc_inc   = w_pc_inc & ~reset;
  assign read     = w_read & ~reset;
  assign RE       = reset ? 4'd0 : w_re;
  assign WE       = reset ? 16'h0000 : w_we;
  assign alu_ld_r = reset ? 8'h00 : w_ld;
  assign alu_re_r = reset ? 4'd0 : w_are;
  assign alu_op   = reset ? 3'd0 : w_op;
  assign ir       = reset ? 8'h00 : r_ir;
  assign halted   = w_hlt & ~reset;
  assign illegal  = w_ill & ~reset;

endmodule
